// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store over a req/ack data bus, stall request while pending.
// Optional macro MEM_ALIGN_CHECK_EN traps misaligned half/word accesses instead of issuing them.
package mem_stage_pkg;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg1_i,
  input  logic        mem_stall_i,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        we_o,
  output logic        stallreq_o,
  output logic        dreq_o,
  output logic        dwe_o,
  output logic [3:0]  dbe_o,
  output logic [31:0] daddr_o,
  output logic [31:0] dwdata_o,
  input  logic        dack_i,
  input  logic [31:0] drdata_i,
  output logic        excp_ale_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [31:0] rdata_q;

  logic [1:0]  a;
  logic        is_load, is_store, misaligned, access;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  assign a = mem_addr_i[1:0];

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    be       = 4'b0000;
    wd       = 32'h0;
    case (aluop_i)
      OP_LB, OP_LBU: begin is_load = 1'b1;  be = 4'b0001 << a; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  be = a[1] ? 4'b1100 : 4'b0011; end
      OP_LW:         begin is_load = 1'b1;  be = 4'b1111; end
      OP_SB: begin is_store = 1'b1; be = 4'b0001 << a;  wd = {4{reg1_i[7:0]}};  end
      OP_SH: begin is_store = 1'b1; be = a[1] ? 4'b1100 : 4'b0011; wd = {2{reg1_i[15:0]}}; end
      OP_SW: begin is_store = 1'b1; be = 4'b1111;       wd = reg1_i; end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (aluop_i)
      OP_LH, OP_LHU, OP_SH: misaligned = a[0];
      OP_LW, OP_SW:         misaligned = |a;
      default: ;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Only an IDLE-cycle op can start an access; WAIT/DONE see the same held op.
  assign access = (state == IDLE) && (is_load || is_store) && !misaligned;

  always_comb begin
    case (a)
      2'd0:    byte_lane = rdata_q[7:0];
      2'd1:    byte_lane = rdata_q[15:8];
      2'd2:    byte_lane = rdata_q[23:16];
      default: byte_lane = rdata_q[31:24];
    endcase
    half_lane = a[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (aluop_i)
      OP_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_data = {24'h0, byte_lane};
      OP_LH:   load_data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_data = {16'h0, half_lane};
      default: load_data = rdata_q;
    endcase
  end

  assign dreq_o     = access || (state == WAIT);
  assign stallreq_o = dreq_o;
  assign dwe_o      = dreq_o && is_store;
  assign dbe_o      = dreq_o ? be : 4'b0000;
  assign dwdata_o   = dreq_o ? wd : 32'h0;
  assign daddr_o    = {mem_addr_i[31:2], 2'b00};

  assign excp_ale_o = (state == IDLE) && misaligned;
  assign waddr_o    = waddr_i;
  assign we_o       = excp_ale_o ? 1'b0 : we_i;
  assign wdata_o    = (state == DONE && is_load) ? load_data : wdata_i;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: if (access) begin
          if (dack_i) begin
            state   <= DONE;
            rdata_q <= drdata_i;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (dack_i) begin
          state   <= DONE;
          rdata_q <= drdata_i;
        end
        DONE: if (!mem_stall_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes per-cycle expected outputs, a monitor checks them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [7:0] OP_ADD = 8'b0010_0000;

  typedef struct packed {
    logic        rst;
    logic [7:0]  aluop;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] addr;
    logic [31:0] reg1;
    logic        mem_stall;
    logic        dack;
    logic [31:0] drdata;
  } stim_t;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        stallreq;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        excp;
    logic [15:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  waddr_i, waddr_o;
  logic [31:0] wdata_i, wdata_o;
  logic        we_i, we_o;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg1_i;
  logic        mem_stall_i;
  logic        stallreq_o, dreq_o, dwe_o;
  logic [3:0]  dbe_o;
  logic [31:0] daddr_o, dwdata_o;
  logic        dack_i;
  logic [31:0] drdata_i;
  logic        excp_ale_o;

  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg1_i(reg1_i), .mem_stall_i(mem_stall_i),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o), .stallreq_o(stallreq_o),
    .dreq_o(dreq_o), .dwe_o(dwe_o), .dbe_o(dbe_o), .daddr_o(daddr_o), .dwdata_o(dwdata_o),
    .dack_i(dack_i), .drdata_i(drdata_i), .excp_ale_o(excp_ale_o)
  );

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle away from the edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("waddr_o",    e.id, 32'(waddr_o),    32'(e.waddr));
      check("wdata_o",    e.id, wdata_o,         e.wdata);
      check("we_o",       e.id, 32'(we_o),       32'(e.we));
      check("stallreq_o", e.id, 32'(stallreq_o), 32'(e.stallreq));
      check("dreq_o",     e.id, 32'(dreq_o),     32'(e.dreq));
      check("dwe_o",      e.id, 32'(dwe_o),      32'(e.dwe));
      check("dbe_o",      e.id, 32'(dbe_o),      32'(e.dbe));
      check("daddr_o",    e.id, daddr_o,         e.daddr);
      check("dwdata_o",   e.id, dwdata_o,        e.dwdata);
      check("excp_ale_o", e.id, 32'(excp_ale_o), 32'(e.excp));
    end
  end

  function automatic stim_t st(input logic [7:0] op, input logic [4:0] wa, input logic [31:0] wd,
                               input logic we, input logic [31:0] addr, input logic [31:0] r1);
    stim_t s;
    s = '0;
    s.aluop = op; s.waddr = wa; s.wdata = wd; s.we = we; s.addr = addr; s.reg1 = r1;
    return s;
  endfunction

  function automatic exp_t ex(input logic [4:0] wa, input logic [31:0] wd, input logic we,
                              input logic stall, input logic dreq, input logic dwe, input logic [3:0] dbe,
                              input logic [31:0] daddr, input logic [31:0] dwd, input logic excp);
    exp_t e;
    e = '0;
    e.waddr = wa; e.wdata = wd; e.we = we; e.stallreq = stall; e.dreq = dreq; e.dwe = dwe;
    e.dbe = dbe; e.daddr = daddr; e.dwdata = dwd; e.excp = excp;
    return e;
  endfunction

  task automatic step(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst = s.rst; aluop_i = s.aluop; waddr_i = s.waddr; wdata_i = s.wdata; we_i = s.we;
    mem_addr_i = s.addr; reg1_i = s.reg1; mem_stall_i = s.mem_stall;
    dack_i = s.dack; drdata_i = s.drdata;
    step_id++;
    e.id = 16'(step_id);
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s, nop;
    exp_t  e, zero;
    nop  = st(8'h00, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
    zero = ex(5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    rst = 1'b1; aluop_i = '0; waddr_i = '0; wdata_i = '0; we_i = 1'b0;
    mem_addr_i = '0; reg1_i = '0; mem_stall_i = 1'b0; dack_i = 1'b0; drdata_i = '0;
    repeat (2) @(posedge clk);

    // Reset state with NOP input, then released
    s = nop; s.rst = 1'b1; step(s, zero);
    step(nop, zero);

    // ADD pass-through
    step(st(OP_ADD, 5'd5, 32'h1234, 1'b1, 32'h0, 32'h0),
         ex(5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0));

    // LB 0x103, three wait cycles then ack
    s = st(OP_LB, 5'd7, 32'h0, 1'b1, 32'h103, 32'h0);
    e = ex(5'd7, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 32'h100, 32'h0, 1'b0);
    repeat (3) step(s, e);
    s.dack = 1'b1; s.drdata = 32'h80FF_FF00;
    step(s, e);
    s.dack = 1'b0; s.drdata = 32'h1234_5678;
    step(s, ex(5'd7, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0));
    step(nop, zero);

    // SH 0x202 with same-cycle ack
    s = st(OP_SH, 5'd0, 32'h202, 1'b0, 32'h202, 32'hABCD_1234); s.dack = 1'b1;
    step(s, ex(5'd0, 32'h202, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, 32'h200, 32'h1234_1234, 1'b0));
    s.dack = 1'b0;
    step(s, ex(5'd0, 32'h202, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h200, 32'h0, 1'b0));
    step(nop, zero);

    // LHU 0x10, DONE held by mem_stall_i; a stray ack in DONE must not recapture
    s = st(OP_LHU, 5'd3, 32'h10, 1'b1, 32'h10, 32'h0); s.dack = 1'b1; s.drdata = 32'h1111_BEEF;
    step(s, ex(5'd3, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0011, 32'h10, 32'h0, 1'b0));
    e = ex(5'd3, 32'h0000_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    s.mem_stall = 1'b1; s.dack = 1'b1; s.drdata = 32'hFFFF_FFFF;
    step(s, e);
    s.dack = 1'b0;
    step(s, e);
    s.mem_stall = 1'b0;
    step(s, e);
    step(nop, zero);

    // LW 0x20, reset while waiting, late ack ignored
    s = st(OP_LW, 5'd9, 32'h20, 1'b1, 32'h20, 32'h0);
    e = ex(5'd9, 32'h20, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0);
    step(s, e);
    step(s, e);
    s.rst = 1'b1;
    step(s, e);
    s = nop; s.dack = 1'b1; s.drdata = 32'hDEAD_BEEF;
    step(s, zero);
    step(nop, zero);

    // LW 0x6 misaligned
    s = st(OP_LW, 5'd4, 32'h6, 1'b1, 32'h6, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    e = ex(5'd4, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1);
    step(s, e);
    step(s, e);
`else
    s.dack = 1'b1; s.drdata = 32'hCAFE_F00D;
    step(s, ex(5'd4, 32'h6, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 32'h4, 32'h0, 1'b0));
    s.dack = 1'b0;
    step(s, ex(5'd4, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h4, 32'h0, 1'b0));
`endif
    step(nop, zero);

    // Back-to-back SB / LBU / LH, each issuing in the IDLE cycle after DONE
    s = st(OP_SB, 5'd0, 32'h301, 1'b0, 32'h301, 32'h0000_005A); s.dack = 1'b1;
    step(s, ex(5'd0, 32'h301, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010, 32'h300, 32'h5A5A_5A5A, 1'b0));
    s.dack = 1'b0;
    step(s, ex(5'd0, 32'h301, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h300, 32'h0, 1'b0));
    s = st(OP_LBU, 5'd2, 32'h302, 1'b1, 32'h302, 32'h0); s.dack = 1'b1; s.drdata = 32'h009C_0000;
    step(s, ex(5'd2, 32'h302, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 32'h300, 32'h0, 1'b0));
    s.dack = 1'b0;
    step(s, ex(5'd2, 32'h0000_009C, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h300, 32'h0, 1'b0));
    s = st(OP_LH, 5'd6, 32'h402, 1'b1, 32'h402, 32'h0); s.dack = 1'b1; s.drdata = 32'h8001_0000;
    step(s, ex(5'd6, 32'h402, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1100, 32'h400, 32'h0, 1'b0));
    s.dack = 1'b0;
    step(s, ex(5'd6, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h400, 32'h0, 1'b0));
    step(nop, zero);

    repeat (2) @(posedge clk);
    check("scoreboard_drain", step_id, 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
